// File: rtl/aes_sbox_arbiter.sv
// Shared AES S-box plus a round-robin arbiter that serialises key-schedule SubWord and
// round SubBytes requests through it, one byte per clock.

module aes_sbox #(
    parameter string IMPL = "LUT"
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (square-and-multiply), then the AES affine transform.
    function automatic logic [7:0] sbox_logic(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        if (x == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    generate
        if (IMPL == "LOGIC") begin : g_logic
            assign dout = sbox_logic(din);
        end else begin : g_lut
            // Entry 0 sits in the most significant byte.
            localparam logic [2047:0] SboxTable = {
                128'h637c777bf26b6fc53001672bfed7ab76,
                128'hca82c97dfa5947f0add4a2af9ca472c0,
                128'hb7fd9326363ff7cc34a5e5f171d83115,
                128'h04c723c31896059a071280e2eb27b275,
                128'h09832c1a1b6e5aa0523bd6b329e32f84,
                128'h53d100ed20fcb15b6acbbe394a4c58cf,
                128'hd0efaafb434d338545f9027f503c9fa8,
                128'h51a3408f929d38f5bcb6da2110fff3d2,
                128'hcd0c13ec5f974417c4a77e3d645d1973,
                128'h60814fdc222a908846eeb814de5e0bdb,
                128'he0323a0a4906245cc2d3ac629195e479,
                128'he7c8376d8dd54ea96c56f4ea657aae08,
                128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
                128'h703eb5664803f60e613557b986c11d9e,
                128'he1f8981169d98e949b1e87e9ce5528df,
                128'h8ca1890dbfe6426841992d0fb054bb16
            };
            logic [10:0] idx;
            assign idx  = {~din, 3'b000};
            assign dout = SboxTable[idx +: 8];
        end
    endgenerate

endmodule

module aes_sbox_arbiter #(
    parameter string IMPL = "LUT"
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ks_req_valid,
    output logic         ks_req_ready,
    input  logic [31:0]  ks_req_word,
    output logic         ks_rsp_valid,
    output logic [31:0]  ks_rsp_word,
    input  logic         rd_req_valid,
    output logic         rd_req_ready,
    input  logic [127:0] rd_req_state,
    output logic         rd_rsp_valid,
    output logic [127:0] rd_rsp_state,
    output logic         busy
);

    typedef enum logic [2:0] {
        StIdle,
        StBusyKs,
        StBusyRd,
        StDoneKs,
        StDoneRd
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   operand_q, operand_d;
    logic [127:0]   result_q, result_d;
    logic           last_ks_q, last_ks_d;
    logic [31:0]    ks_word_q, ks_word_d;
    logic [127:0]   rd_state_q, rd_state_d;
    logic [6:0]     bit_idx;
    logic [7:0]     sbox_in;
    logic [7:0]     sbox_out;

    assign bit_idx = {cnt_q, 3'b000};
    assign sbox_in = operand_q[bit_idx +: 8];

    aes_sbox #(
        .IMPL (IMPL)
    ) u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        operand_d    = operand_q;
        result_d     = result_q;
        last_ks_d    = last_ks_q;
        ks_word_d    = ks_word_q;
        rd_state_d   = rd_state_q;
        ks_req_ready = 1'b0;
        rd_req_ready = 1'b0;
        ks_rsp_valid = 1'b0;
        rd_rsp_valid = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie, whoever was not served last wins.
                ks_req_ready = !rd_req_valid || !last_ks_q;
                rd_req_ready = !ks_req_valid || last_ks_q;
                if (ks_req_valid && ks_req_ready) begin
                    operand_d = {96'b0, ks_req_word};
                    result_d  = '0;
                    cnt_d     = 4'd0;
                    last_ks_d = 1'b1;
                    state_d   = StBusyKs;
                end else if (rd_req_valid && rd_req_ready) begin
                    operand_d = rd_req_state;
                    result_d  = '0;
                    cnt_d     = 4'd0;
                    last_ks_d = 1'b0;
                    state_d   = StBusyRd;
                end
            end
            StBusyKs: begin
                result_d[bit_idx +: 8] = sbox_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    ks_word_d = result_d[31:0];
                    state_d   = StDoneKs;
                end
            end
            StBusyRd: begin
                result_d[bit_idx +: 8] = sbox_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    rd_state_d = result_d;
                    state_d    = StDoneRd;
                end
            end
            StDoneKs: begin
                ks_rsp_valid = 1'b1;
                state_d      = StIdle;
            end
            StDoneRd: begin
                rd_rsp_valid = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            operand_q  <= '0;
            result_q   <= '0;
            last_ks_q  <= 1'b0;
            ks_word_q  <= '0;
            rd_state_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            last_ks_q  <= last_ks_d;
            ks_word_q  <= ks_word_d;
            rd_state_q <= rd_state_d;
        end
    end

    assign ks_rsp_word  = ks_word_q;
    assign rd_rsp_state = rd_state_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Scoreboard bench for aes_sbox_arbiter: requests push expected data and response edge,
// a negedge monitor pops and compares on every response pulse.

module tb_aes_sbox_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ks_req_valid = 1'b0;
    logic         ks_req_ready;
    logic [31:0]  ks_req_word = '0;
    logic         ks_rsp_valid;
    logic [31:0]  ks_rsp_word;
    logic         rd_req_valid = 1'b0;
    logic         rd_req_ready;
    logic [127:0] rd_req_state = '0;
    logic         rd_rsp_valid;
    logic [127:0] rd_rsp_state;
    logic         busy;

    aes_sbox_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ks_req_valid (ks_req_valid),
        .ks_req_ready (ks_req_ready),
        .ks_req_word  (ks_req_word),
        .ks_rsp_valid (ks_rsp_valid),
        .ks_rsp_word  (ks_rsp_word),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_state (rd_req_state),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_state (rd_rsp_state),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [127:0] data;
        int unsigned  edge_n;
    } exp_t;

    exp_t         ks_q[$];
    exp_t         rd_q[$];
    logic [31:0]  ks_held = '0;
    logic [127:0] rd_held = '0;
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] RdSeq    = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] RdSeqExp = 128'h76ABD7FE2B670130C56F6BF27B777C63;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic ks_send(input logic [31:0] w, input logic [31:0] exp, input bit keep,
                           output int unsigned acc);
        int n;
        n = 0;
        ks_req_valid = 1'b1;
        ks_req_word  = w;
        while (!ks_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("ks_accept");
            ks_req_valid = 1'b0;
            acc = 0;
            return;
        end
        acc = edge_cnt + 1;
        ks_q.push_back('{data: {96'b0, exp}, edge_n: acc + 4});
        @(negedge clk);
        if (!keep) ks_req_valid = 1'b0;
        ks_req_word = ~w;
    endtask

    task automatic rd_send(input logic [127:0] s, input logic [127:0] exp,
                           output int unsigned acc);
        int n;
        n = 0;
        rd_req_valid = 1'b1;
        rd_req_state = s;
        while (!rd_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("rd_accept");
            rd_req_valid = 1'b0;
            acc = 0;
            return;
        end
        acc = edge_cnt + 1;
        rd_q.push_back('{data: exp, edge_n: acc + 16});
        @(negedge clk);
        rd_req_valid = 1'b0;
        rd_req_state = ~s;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("wait_idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        ks_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        ks_q.delete();
        rd_q.delete();
        ks_held = '0;
        rd_held = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ks_rsp_valid) begin
                if (ks_q.size() == 0) begin
                    fail_now("ks_unexpected_rsp");
                end else begin
                    e = ks_q.pop_front();
                    check("ks_rsp_word", {96'b0, ks_rsp_word}, e.data);
                    check("ks_rsp_edge", edge_cnt, e.edge_n);
                    check("ks_rd_isolation", rd_rsp_state, rd_held);
                    ks_held = e.data[31:0];
                end
            end
            if (rd_rsp_valid) begin
                if (rd_q.size() == 0) begin
                    fail_now("rd_unexpected_rsp");
                end else begin
                    e = rd_q.pop_front();
                    check("rd_rsp_state", rd_rsp_state, e.data);
                    check("rd_rsp_edge", edge_cnt, e.edge_n);
                    check("rd_ks_isolation", {96'b0, ks_rsp_word}, {96'b0, ks_held});
                    rd_held = e.data;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned a_ks, a_rd, a1, a2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ks_ready", ks_req_ready, 1'b1);
        check("idle_rd_ready", rd_req_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_ks_valid", ks_rsp_valid, 1'b0);
        check("idle_rd_valid", rd_rsp_valid, 1'b0);
        check("idle_ks_word", ks_rsp_word, 32'h0);
        check("idle_rd_state", rd_rsp_state, 128'h0);
        @(negedge clk);

        ks_send(32'h000152FF, 32'h637C0016, 1'b0, a_ks);
        #1 check("busy_after_accept", busy, 1'b1);
        @(negedge clk);
        wait_idle();
        rd_send(RdSeq, RdSeqExp, a_rd);
        wait_idle();

        // Simultaneous pairs after reset: KS wins both, RD follows 6 edges later.
        do_reset();
        ks_req_valid = 1'b1;
        ks_req_word  = 32'h00000000;
        rd_req_valid = 1'b1;
        rd_req_state = {16{8'hFF}};
        #1;
        check("tie1_ks_ready", ks_req_ready, 1'b1);
        check("tie1_rd_ready", rd_req_ready, 1'b0);
        ks_send(32'h00000000, 32'h63636363, 1'b0, a_ks);
        rd_send({16{8'hFF}}, {16{8'h16}}, a_rd);
        check("tie1_rd_accept_edge", a_rd, a_ks + 6);
        wait_idle();

        ks_req_valid = 1'b1;
        ks_req_word  = 32'h01010101;
        rd_req_valid = 1'b1;
        rd_req_state = RdSeq;
        #1;
        check("tie2_ks_ready", ks_req_ready, 1'b1);
        check("tie2_rd_ready", rd_req_ready, 1'b0);
        ks_send(32'h01010101, 32'h7C7C7C7C, 1'b0, a_ks);
        rd_send(RdSeq, RdSeqExp, a_rd);
        check("tie2_rd_accept_edge", a_rd, a_ks + 6);
        wait_idle();

        // Reset after the 7th byte capture of an RD request.
        rd_send(RdSeq, RdSeqExp, a_rd);
        while (edge_cnt < a_rd + 7) @(negedge clk);
        rst_n = 1'b0;
        rd_q.delete();
        ks_held = '0;
        rd_held = '0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_valid", rd_rsp_valid, 1'b0);
        check("midrst_rd_state", rd_rsp_state, 128'h0);
        check("midrst_ks_word", ks_rsp_word, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ks_ready", ks_req_ready, 1'b1);
        check("midrst_rd_ready", rd_req_ready, 1'b1);
        repeat (25) @(negedge clk);

        ks_send(32'h01010101, 32'h7C7C7C7C, 1'b1, a1);
        ks_send(32'h10101010, 32'hCACACACA, 1'b0, a2);
        check("b2b_accept_gap", a2 - a1, 6);
        wait_idle();
        repeat (4) @(negedge clk);

        check("ks_queue_drained", ks_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sbox_arbiter.md
# aes_sbox_arbiter

Sequential arbiter that time-shares a single `aes_sbox` instance between two requesters: the AES key-schedule (SubWord, 4 bytes) and the round datapath (SubBytes, 16 bytes). It accepts one request at a time through a valid/ready handshake. It substitutes one byte per clock through the shared S-box and returns the full substituted word or state as a one-cycle response pulse. It sits between the key-expansion/round controllers and the S-box, and trades throughput for one S-box instead of twenty.

## Interface
Parameters:
- `IMPL`, default "LUT": passed unchanged to the internal `aes_sbox` instance ("LUT" or "LOGIC").

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ks_req_valid`  in  1  key-schedule request valid.
- `ks_req_ready`  out  1  key-schedule request accepted when high with valid.
- `ks_req_word`  in  32  SubWord operand; byte i = bits [8i+7:8i].
- `ks_rsp_valid`  out  1  one-cycle pulse: `ks_rsp_word` is fresh.
- `ks_rsp_word`  out  32  substituted word; held until the next KS completion.
- `rd_req_valid`  in  1  round request valid.
- `rd_req_ready`  out  1  round request accepted when high with valid.
- `rd_req_state`  in  128  SubBytes operand; byte i = bits [8i+7:8i].
- `rd_rsp_valid`  out  1  one-cycle pulse: `rd_rsp_state` is fresh.
- `rd_rsp_state`  out  128  substituted state; held until the next RD completion.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, BUSY_KS, BUSY_RD, DONE_KS, DONE_RD. The reset state is IDLE.
- **Reset values:** all rsp outputs, the operand/result registers and the byte counter are 0. `last_served` is RD.
- **Ready outputs:** only in IDLE; both readies are 0 in every other state.
  - `ks_req_ready = !rd_req_valid || last_served==RD`
  - `rd_req_ready = !ks_req_valid || last_served==KS`
  - With no requests pending, both are high.
  - Requesters must not make valid depend on ready.
- **Arbitration:** round-robin on simultaneous valids. After reset, a tie goes to KS. A single requester is always granted immediately.
- **Accept edge (valid && ready in IDLE):**
  - latch the operand;
  - clear the byte counter;
  - set `last_served`;
  - go to BUSY_KS or BUSY_RD.
- **BUSY:**
  - S-box input = operand byte[counter].
  - On each edge, the S-box output is written to result byte[counter] and the counter increments.
  - The capture of byte 3 (KS) or byte 15 (RD) moves the FSM to DONE_KS or DONE_RD.
- **DONE_x:**
  - `x_rsp_valid` = 1 for exactly that cycle;
  - `x_rsp_word`/`x_rsp_state` are updated from the result register;
  - next edge returns to IDLE.
- **Result isolation:** the other requester's rsp output is untouched.
- **Stable inputs:** operand inputs are sampled only at the accept edge; later changes have no effect on an in-flight request.
- **Counter width:** 4 bits. KS terminates at 3 and never wraps into bytes 4..15.
- **Reset mid-operation:**
  - immediate return to IDLE;
  - in-flight request discarded;
  - no rsp pulse;
  - held rsp data cleared to 0.

## Timing
- Accept at edge E:
  - KS: bytes captured at E+1..E+4; `ks_rsp_valid` high for the cycle after E+4.
  - RD: captured at E+1..E+16; `rd_rsp_valid` high for the cycle after E+16.
- The FSM is back in IDLE after edge E+5 (KS) or E+17 (RD).
- Earliest next accept: edge E+6 (KS) or E+18 (RD).
- Maximum throughput: one KS per 6 cycles, one RD per 18 cycles.
- The S-box path is combinational within one cycle: counter → byte mux → `aes_sbox` → result register.
- `busy` is registered from the state and goes high the cycle after the accept edge.

## Test plan
- **Idle after reset:**
  - Stimulus: hold `rst_n` low, then release with no requests.
  - Required: both readies = 1, `busy` = 0, rsp valids = 0, `ks_rsp_word` = 0, `rd_rsp_state` = 0.
- **KS request:**
  - Stimulus: `ks_req_word` = 32'h000152FF.
  - Required: `ks_rsp_valid` exactly 4 cycles after the accept edge, `ks_rsp_word` = 32'h637C0016; `rd_rsp_state` unchanged.
- **RD request:**
  - Stimulus: `rd_req_state` = 128'h0F0E0D0C0B0A09080706050403020100.
  - Required: `rd_rsp_valid` 16 cycles after accept, `rd_rsp_state` = 128'h76ABD7FE2B670130C56F6BF27B777C63.
- **Simultaneous requests after reset (KS = 32'h00000000, RD = all 8'hFF bytes):**
  - Required: KS is granted first and returns 32'h63636363.
  - Required: RD is accepted at the edge after the KS rsp cycle ends and returns all bytes 8'h16.
  - Stimulus: a second simultaneous pair.
  - Required: KS is granted again, because the last served was RD.
- **Reset mid-operation:**
  - Stimulus: during an RD request, drop `rst_n` after the 7th byte capture.
  - Required: no `rd_rsp_valid`, `rd_rsp_state` = 0, `busy` = 0 immediately; readies are high after release.
- **Back-to-back KS:**
  - Stimulus: hold `ks_req_valid` continuously for words 32'h01010101 and 32'h10101010.
  - Required: accepts 6 cycles apart; responses 32'h7C7C7C7C then 32'hCACACACA.
